miner_nonce_sequencer: RTL
==========================

# miner_nonce_sequencer

Control stage directly upstream of the SHA3-256 miner core. It is an Avalon-MM slave on the HPS lightweight bridge that holds the nonce range and control/status registers. It issues nonces to the hash core over a valid/ready handshake, tracks results still in flight, and captures the first winning nonce. It also drives the `bsy` conduit that reaches the board LED.

## Interface
Parameters:
- NONCE_W, 32, nonce width; also the width of the CSR data fields that hold nonces
- OUT_W, 6, width of the in-flight counter; at most 2^OUT_W−1 nonces are in flight

Ports:
- clk  in  1  single clock domain; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- avs_address  in  3  CSR word address
- avs_write  in  1  write strobe, single cycle
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, registered, fixed 1-cycle read latency
- core_nonce  out  NONCE_W  nonce offered to the core
- core_valid  out  1  nonce valid
- core_ready  in  1  core accepts the nonce; a transfer happens when core_valid & core_ready
- res_valid  in  1  one result returned this cycle
- res_hit  in  1  the result meets the target
- res_nonce  in  NONCE_W  nonce the result belongs to
- bsy  out  1  sequencer not IDLE
- irq  out  1  interrupt, level-high

## Operation
- CSR map (word addresses):
  - 0 CTRL: write bit0 = start, bit1 = stop; read bit0 = bsy, bit1 = found, bit2 = exhausted.
  - 1 NONCE_START (RW).
  - 2 NONCE_END (RW, inclusive).
  - 3 FOUND_NONCE (RO).
  - 4 ISSUED (RO, 32-bit count of transfers since the last start; wraps).
  - 5 IRQ, see Configuration.
  - 6–7 read 0; writes ignored.
- States IDLE, RUN, DRAIN.
- IDLE, start written:
  - If NONCE_START ≤ NONCE_END: clear found, exhausted and ISSUED; load the nonce counter with NONCE_START; go to RUN.
  - Otherwise: set exhausted and stay in IDLE.
- Start written in RUN or DRAIN: ignored.
- RUN:
  - core_valid = 1 unless the in-flight count equals 2^OUT_W−1.
  - On each transfer, increment the nonce counter and ISSUED.
  - If the transferred nonce equals NONCE_END: set exhausted and go to DRAIN. Equality compare, so NONCE_END = all-ones does not wrap.
  - Stop written: go to DRAIN.
- res_valid & res_hit while found = 0: capture res_nonce into FOUND_NONCE, set found, go to DRAIN (from RUN). Later hits are ignored.
- DRAIN: core_valid = 0. Go to IDLE when the in-flight count is 0.
- In-flight counter:
  - +1 on a transfer, −1 on res_valid; both in the same cycle leaves it unchanged.
  - res_valid with the count at 0 is a protocol error: the count saturates at 0.
- Simultaneous end-of-range transfer and hit in the same cycle: found and exhausted are both set; one transition to DRAIN.
- NONCE_START and NONCE_END writes are accepted in any state but only take effect at the next start.
- Reset mid-operation: all state is lost; core_valid drops asynchronously; in-flight results that arrive afterwards are ignored.

## Timing
- Reset values: avs_readdata 0, core_valid 0, core_nonce 0, bsy 0, irq 0; all registers 0; state IDLE.
- Start write in cycle N: state is RUN and core_valid = 1 in cycle N+1.
- Peak issue rate is one nonce per clock while core_ready stays high.
- core_nonce is stable while core_valid & !core_ready.
- Hit in cycle N: core_valid = 0 from cycle N+1.
- bsy is registered and equals (state != IDLE).
- CSR reads return the value as of the cycle of avs_read.

## Configuration
- MINER_IRQ_EN defined:
  - Register 5 bit0 = irq enable (RW); bit1 = pending, which reads 1 and is cleared by writing 1.
  - Pending is set on the DRAIN→IDLE transition.
  - irq = enable & pending.
- Not defined: irq tied 0; register 5 reads 0; writes to it are ignored.

## Structure
- Shared package miner_pkg holds:
  - CSR address constants;
  - CTRL and IRQ bit positions;
  - the state enum (IDLE, RUN, DRAIN).
- Single module; no sub-module needed. CSR decode, FSM, nonce counter and in-flight counter stay inline.

## Test plan
- START=0x10, END=0x13, core_ready=1, results returned 4 cycles later with no hit → nonces 0x10..0x13 issued on consecutive cycles; exhausted=1; ISSUED=4; bsy falls after the last result.
- START=0x100, END=0x1FF, hit returned for 0x105 → FOUND_NONCE=0x105, found=1, no transfers after the hit cycle, DRAIN waits for outstanding results, then IDLE.
- OUT_W=2, core_ready=1, no results → exactly 3 transfers, then core_valid=0 until a res_valid arrives.
- START=0xFFFFFFFE, END=0xFFFFFFFF → two nonces issued, no wrap to 0, exhausted=1.
- START=5, END=4 → exhausted=1, bsy stays 0, no transfers.
- With MINER_IRQ_EN and enable=1: irq=1 after completion; writing 0x2 to register 5 → irq=0 the next cycle; reset_n pulsed during RUN → all outputs return to their reset values.

Source files
------------

// File: rtl/miner_pkg.sv
// Shared definitions for the miner nonce sequencer: CSR map, bit positions and FSM states.
package miner_pkg;

  localparam int unsigned CSR_AW = 3;
  localparam int unsigned CSR_DW = 32;

  localparam logic [CSR_AW-1:0] ADDR_CTRL   = 3'd0;
  localparam logic [CSR_AW-1:0] ADDR_START  = 3'd1;
  localparam logic [CSR_AW-1:0] ADDR_END    = 3'd2;
  localparam logic [CSR_AW-1:0] ADDR_FOUND  = 3'd3;
  localparam logic [CSR_AW-1:0] ADDR_ISSUED = 3'd4;
  localparam logic [CSR_AW-1:0] ADDR_IRQ    = 3'd5;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_STOP_BIT  = 1;
  localparam int unsigned CTRL_BSY_BIT   = 0;
  localparam int unsigned CTRL_FOUND_BIT = 1;
  localparam int unsigned CTRL_EXH_BIT   = 2;

  localparam int unsigned IRQ_EN_BIT   = 0;
  localparam int unsigned IRQ_PEND_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/miner_nonce_sequencer.sv
// Nonce issue/CSR control stage in front of the SHA3 miner core.
// Optional completion interrupt enabled by defining MINER_IRQ_EN.
module miner_nonce_sequencer
  import miner_pkg::*;
#(
  parameter int unsigned NONCE_W = 32,
  parameter int unsigned OUT_W   = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [CSR_AW-1:0]  avs_address,
  input  logic               avs_write,
  input  logic [CSR_DW-1:0]  avs_writedata,
  input  logic               avs_read,
  output logic [CSR_DW-1:0]  avs_readdata,
  output logic [NONCE_W-1:0] core_nonce,
  output logic               core_valid,
  input  logic               core_ready,
  input  logic               res_valid,
  input  logic               res_hit,
  input  logic [NONCE_W-1:0] res_nonce,
  output logic               bsy,
  output logic               irq
);

  localparam logic [OUT_W-1:0] OUT_MAX = '1;

  state_t             state_q, state_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] start_q, start_d;
  logic [NONCE_W-1:0] end_q, end_d;
  logic [NONCE_W-1:0] run_end_q, run_end_d;
  logic [NONCE_W-1:0] found_nonce_q, found_nonce_d;
  logic [CSR_DW-1:0]  issued_q, issued_d;
  logic [OUT_W-1:0]   inflight_q, inflight_d;
  logic [CSR_DW-1:0]  rdata_q, rdata_d;
  logic               found_q, found_d;
  logic               exh_q, exh_d;
  logic               valid_q, valid_d;
  logic               bsy_q, bsy_d;
`ifdef MINER_IRQ_EN
  logic               irq_en_q, irq_en_d;
  logic               irq_pend_q, irq_pend_d;
  logic               irq_q, irq_d;
`endif

  logic xfer_c, hit_c, wr_ctrl_c;

  assign xfer_c    = valid_q & core_ready;
  assign hit_c     = res_valid & res_hit & ~found_q & (state_q != ST_IDLE);
  assign wr_ctrl_c = avs_write & (avs_address == ADDR_CTRL);

  // Next-state, counters and CSR logic
  always_comb begin
    state_d       = state_q;
    nonce_d       = nonce_q;
    start_d       = start_q;
    end_d         = end_q;
    run_end_d     = run_end_q;
    found_nonce_d = found_nonce_q;
    issued_d      = issued_q;
    inflight_d    = inflight_q;
    rdata_d       = rdata_q;
    found_d       = found_q;
    exh_d         = exh_q;
`ifdef MINER_IRQ_EN
    irq_en_d      = irq_en_q;
    irq_pend_d    = irq_pend_q;
`endif

    // Result without any outstanding transfer is a protocol error: hold at 0.
    case ({xfer_c, res_valid})
      2'b10:   inflight_d = inflight_q + OUT_W'(1);
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - OUT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (xfer_c) begin
      nonce_d  = nonce_q + NONCE_W'(1);
      issued_d = issued_q + CSR_DW'(1);
    end

    if (avs_write && avs_address == ADDR_START) start_d = NONCE_W'(avs_writedata);
    if (avs_write && avs_address == ADDR_END)   end_d   = NONCE_W'(avs_writedata);

    case (state_q)
      ST_IDLE: begin
        if (wr_ctrl_c && avs_writedata[CTRL_START_BIT]) begin
          if (start_q <= end_q) begin
            found_d   = 1'b0;
            exh_d     = 1'b0;
            issued_d  = '0;
            nonce_d   = start_q;
            run_end_d = end_q;
            state_d   = ST_RUN;
          end else begin
            exh_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Equality compare so an all-ones end never wraps back to zero.
        if (xfer_c && nonce_q == run_end_q) begin
          exh_d   = 1'b1;
          state_d = ST_DRAIN;
        end
        if (wr_ctrl_c && avs_writedata[CTRL_STOP_BIT]) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (inflight_d == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (hit_c) begin
      found_d       = 1'b1;
      found_nonce_d = res_nonce;
      if (state_q == ST_RUN) state_d = ST_DRAIN;
    end

`ifdef MINER_IRQ_EN
    if (avs_write && avs_address == ADDR_IRQ) begin
      irq_en_d = avs_writedata[IRQ_EN_BIT];
      if (avs_writedata[IRQ_PEND_BIT]) irq_pend_d = 1'b0;
    end
    if (state_q == ST_DRAIN && state_d == ST_IDLE) irq_pend_d = 1'b1;
    irq_d = irq_en_d & irq_pend_d;
`endif

    valid_d = (state_d == ST_RUN) && (inflight_d != OUT_MAX);
    bsy_d   = (state_d != ST_IDLE);

    if (avs_read) begin
      rdata_d = '0;
      case (avs_address)
        ADDR_CTRL: begin
          rdata_d[CTRL_BSY_BIT]   = bsy_q;
          rdata_d[CTRL_FOUND_BIT] = found_q;
          rdata_d[CTRL_EXH_BIT]   = exh_q;
        end
        ADDR_START:  rdata_d = CSR_DW'(start_q);
        ADDR_END:    rdata_d = CSR_DW'(end_q);
        ADDR_FOUND:  rdata_d = CSR_DW'(found_nonce_q);
        ADDR_ISSUED: rdata_d = issued_q;
`ifdef MINER_IRQ_EN
        ADDR_IRQ: begin
          rdata_d[IRQ_EN_BIT]   = irq_en_q;
          rdata_d[IRQ_PEND_BIT] = irq_pend_q;
        end
`endif
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      nonce_q       <= '0;
      start_q       <= '0;
      end_q         <= '0;
      run_end_q     <= '0;
      found_nonce_q <= '0;
      issued_q      <= '0;
      inflight_q    <= '0;
      rdata_q       <= '0;
      found_q       <= 1'b0;
      exh_q         <= 1'b0;
      valid_q       <= 1'b0;
      bsy_q         <= 1'b0;
`ifdef MINER_IRQ_EN
      irq_en_q      <= 1'b0;
      irq_pend_q    <= 1'b0;
      irq_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      nonce_q       <= nonce_d;
      start_q       <= start_d;
      end_q         <= end_d;
      run_end_q     <= run_end_d;
      found_nonce_q <= found_nonce_d;
      issued_q      <= issued_d;
      inflight_q    <= inflight_d;
      rdata_q       <= rdata_d;
      found_q       <= found_d;
      exh_q         <= exh_d;
      valid_q       <= valid_d;
      bsy_q         <= bsy_d;
`ifdef MINER_IRQ_EN
      irq_en_q      <= irq_en_d;
      irq_pend_q    <= irq_pend_d;
      irq_q         <= irq_d;
`endif
    end
  end

  assign avs_readdata = rdata_q;
  assign core_nonce   = nonce_q;
  assign core_valid   = valid_q;
  assign bsy          = bsy_q;
`ifdef MINER_IRQ_EN
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
